// File: rtl/mxn_pair_pkg.sv
// rtl/mxn_pair_pkg.sv - shared defaults and level-width helper for the MxN pair aligner
package mxn_pair_pkg;

  localparam int M_DEF     = 3;
  localparam int N_DEF     = 4;
  localparam int DEPTH_DEF = 4;

  // Level has to count 0..DEPTH inclusive, hence one bit more than the pointer.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/mxn_pair_fifo.sv
// rtl/mxn_pair_fifo.sv - synchronous DEPTH x W pair FIFO, head held after the last pop
module mxn_pair_fifo
  import mxn_pair_pkg::*;
#(
  parameter int W     = 6,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [level_w(DEPTH)-1:0]  level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = level_w(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [W-1:0]  last_q, last_d;
  logic          push_ok;
  logic          pop_ok;

  assign empty    = (level_q == '0);
  assign full     = (level_q == LW'(DEPTH));
  assign level    = level_q;
  assign pop_data = empty ? last_q : mem_q[rd_ptr_q];

  // A pop in the same cycle frees the slot, so a write at full still lands.
  always_comb begin
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    mem_d    = mem_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
    end
    wr_ptr_d = wr_ptr_q + PW'(push_ok);
    rd_ptr_d = rd_ptr_q + PW'(pop_ok);
    level_d  = level_q + LW'(push_ok) - LW'(pop_ok);
    last_d   = pop_ok ? mem_q[rd_ptr_q] : last_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      last_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      last_q   <= last_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/mxn_pair_aligner.sv
// rtl/mxn_pair_aligner.sv - re-aligns and pairs MxN lane outputs into a FIFO; MXN_PAIR_ALIGNER_DROP_CNT_EN adds drop_cnt
module mxn_pair_aligner
  import mxn_pair_pkg::*;
#(
  parameter int M     = M_DEF,
  parameter int N     = N_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      launch,
  input  logic [M-1:0]              lane0,
  input  logic [M-1:0]              lane1,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [M-1:0]              out_lane0,
  output logic [M-1:0]              out_lane1,
  output logic [level_w(DEPTH)-1:0] level,
  output logic                      overflow
`ifdef MXN_PAIR_ALIGNER_DROP_CNT_EN
  ,
  output logic [15:0]               drop_cnt
`endif
);

  logic [2*N-1:0] vld_q, vld_d;
  logic [M-1:0]   dl_q [N];
  logic [M-1:0]   dl_d [N];
  logic           overflow_q, overflow_d;
  logic           wr;
  logic           pop;
  logic           drop;
  logic           full;
  logic           empty;
  logic [2*M-1:0] head;

  // Oldest valid bit and oldest delayed lane0 word both belong to the launch 2N cycles ago.
  always_comb begin
    vld_d    = {vld_q[2*N-2:0], launch};
    dl_d[0]  = lane0;
    for (int i = 1; i < N; i++) begin
      dl_d[i] = dl_q[i-1];
    end
  end

  assign wr   = vld_q[2*N-1];
  assign pop  = out_ready && !empty;
  assign drop = wr && full && !pop;

  mxn_pair_fifo #(
    .W     (2*M),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (wr),
    .push_data ({dl_q[N-1], lane1}),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  assign out_valid = !empty;
  assign out_lane0 = head[2*M-1:M];
  assign out_lane1 = head[M-1:0];

  always_comb begin
    overflow_d = overflow_q || drop;
  end

  assign overflow = overflow_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q      <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < N; i++) begin
        dl_q[i] <= '0;
      end
    end else begin
      vld_q      <= vld_d;
      overflow_q <= overflow_d;
      dl_q       <= dl_d;
    end
  end

`ifdef MXN_PAIR_ALIGNER_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_mxn_pair_aligner.sv
// tb/tb_mxn_pair_aligner.sv - directed table-driven bench for mxn_pair_aligner
module tb_mxn_pair_aligner;

  localparam int M     = 3;
  localparam int N     = 4;
  localparam int DEPTH = 4;
  localparam int LW    = 3;
  localparam int HN    = 1024;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          launch;
  logic [M-1:0]  lane0;
  logic [M-1:0]  lane1;
  logic          out_valid;
  logic          out_ready;
  logic [M-1:0]  out_lane0;
  logic [M-1:0]  out_lane1;
  logic [LW-1:0] level;
  logic          overflow;
`ifdef MXN_PAIR_ALIGNER_DROP_CNT_EN
  logic [15:0]   drop_cnt;
`endif

  always #5 clk = ~clk;

  mxn_pair_aligner #(
    .M     (M),
    .N     (N),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .launch    (launch),
    .lane0     (lane0),
    .lane1     (lane1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_lane0 (out_lane0),
    .out_lane1 (out_lane1),
    .level     (level),
    .overflow  (overflow)
`ifdef MXN_PAIR_ALIGNER_DROP_CNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  typedef struct {
    int rst;
    int l;
    int a;
    int b;
    int r;
    int ev;
    int e0;
    int e1;
    int elvl;
    int eovf;
  } vec_t;

  vec_t        tbl[$];
  int          checks = 0;
  int          errors = 0;
  int          gc = 0;
  logic [M-1:0] h0 [HN];
  logic [M-1:0] h1 [HN];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic add(input int rst, l, a, b, r, ev, e0, e1, elvl, eovf, n);
    vec_t v;
    v.rst = rst; v.l = l; v.a = a; v.b = b; v.r = r;
    v.ev = ev; v.e0 = e0; v.e1 = e1; v.elvl = elvl; v.eovf = eovf;
    for (int k = 0; k < n; k++) tbl.push_back(v);
  endtask

  // Upstream pipeline model: lane0/lane1 replay the launch data N / 2N cycles later.
  task automatic drive(input int rst, l, a, b, r);
    rst_n       = (rst == 0);
    launch      = (l != 0);
    out_ready   = (r != 0);
    h0[gc % HN] = M'(a);
    h1[gc % HN] = M'(b);
    lane0 = (gc >= N)   ? h0[(gc - N) % HN]   : '0;
    lane1 = (gc >= 2*N) ? h1[(gc - 2*N) % HN] : '0;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    gc++;
  endtask

  initial begin
    for (int i = 0; i < HN; i++) begin
      h0[i] = '0;
      h1[i] = '0;
    end

    // single launch: out_valid only 2N+1 cycles after launch
    add(0, 1, 5, 2, 1,  0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 8);
    add(0, 0, 0, 0, 1,  1, 5, 2, 1, 0, 1);
    add(0, 0, 0, 0, 1,  0, 5, 2, 0, 0, 2);
    // backpressure: six launches, last two dropped
    for (int i = 1; i <= 6; i++) add(0, 1, i, 7 - i, 0,  0, 5, 2, 0, 0, 1);
    add(0, 0, 0, 0, 0,  0, 5, 2, 0, 0, 3);
    add(0, 0, 0, 0, 0,  1, 1, 6, 1, 0, 1);
    add(0, 0, 0, 0, 0,  1, 1, 6, 2, 0, 1);
    add(0, 0, 0, 0, 0,  1, 1, 6, 3, 0, 1);
    add(0, 0, 0, 0, 0,  1, 1, 6, 4, 0, 1);
    add(0, 0, 0, 0, 0,  1, 1, 6, 4, 1, 2);
    add(0, 0, 0, 0, 1,  1, 1, 6, 4, 1, 1);
    add(0, 0, 0, 0, 1,  1, 2, 5, 3, 1, 1);
    add(0, 0, 0, 0, 1,  1, 3, 4, 2, 1, 1);
    add(0, 0, 0, 0, 1,  1, 4, 3, 1, 1, 1);
    add(0, 0, 0, 0, 1,  0, 4, 3, 0, 1, 2);
    // reset, then write into a full FIFO while popping
    add(1, 0, 0, 0, 0,  0, 4, 3, 0, 1, 1);
    for (int i = 0; i < 5; i++) add(0, 1, 7 - i, 1 + i, 0,  0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 4);
    add(0, 0, 0, 0, 0,  1, 7, 1, 1, 0, 1);
    add(0, 0, 0, 0, 0,  1, 7, 1, 2, 0, 1);
    add(0, 0, 0, 0, 0,  1, 7, 1, 3, 0, 1);
    add(0, 0, 0, 0, 1,  1, 7, 1, 4, 0, 1);
    add(0, 0, 0, 0, 0,  1, 6, 2, 4, 0, 1);
    add(0, 0, 0, 0, 1,  1, 6, 2, 4, 0, 1);
    add(0, 0, 0, 0, 1,  1, 5, 3, 3, 0, 1);
    add(0, 0, 0, 0, 1,  1, 4, 4, 2, 0, 1);
    add(0, 0, 0, 0, 1,  1, 3, 5, 1, 0, 1);
    add(0, 0, 0, 0, 1,  0, 3, 5, 0, 0, 1);
    // reset while three launches are in flight
    for (int i = 1; i <= 3; i++) add(0, 1, i, i, 1,  0, 3, 5, 0, 0, 1);
    add(1, 0, 0, 0, 1,  0, 3, 5, 0, 0, 1);
    add(0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 11);

    drive(1, 0, 0, 0, 0);
    advance();
    drive(1, 0, 0, 0, 0);
    advance();
    drive(0, 0, 0, 0, 0);
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset level",     int'(level),     0);
    chk("reset overflow",  int'(overflow),  0);
    chk("reset out_lane0", int'(out_lane0), 0);
    chk("reset out_lane1", int'(out_lane1), 0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].l, tbl[i].a, tbl[i].b, tbl[i].r);
      chk($sformatf("row%0d out_valid", i), int'(out_valid), tbl[i].ev);
      chk($sformatf("row%0d out_lane0", i), int'(out_lane0), tbl[i].e0);
      chk($sformatf("row%0d out_lane1", i), int'(out_lane1), tbl[i].e1);
      chk($sformatf("row%0d level", i),     int'(level),     tbl[i].elvl);
      chk($sformatf("row%0d overflow", i),  int'(overflow),  tbl[i].eovf);
      advance();
    end

    // continuous stream: 20 back-to-back launches with out_ready held high
    for (int c = 0; c < 32; c++) begin
      int ev;
      drive(0, (c < 20) ? 1 : 0, c % 8, (c + 3) % 8, 1);
      ev = (c >= 9 && c < 29) ? 1 : 0;
      chk($sformatf("stream c%0d out_valid", c), int'(out_valid), ev);
      chk($sformatf("stream c%0d level", c),     int'(level),     ev);
      chk($sformatf("stream c%0d overflow", c),  int'(overflow),  0);
      if (ev != 0) begin
        chk($sformatf("stream c%0d out_lane0", c), int'(out_lane0), (c - 9) % 8);
        chk($sformatf("stream c%0d out_lane1", c), int'(out_lane1), (c - 9 + 3) % 8);
      end
      advance();
    end

`ifdef MXN_PAIR_ALIGNER_DROP_CNT_EN
    drive(1, 0, 0, 0, 0);
    advance();
    chk("drop_cnt after reset", int'(drop_cnt), 0);
    for (int c = 0; c < 70010; c++) begin
      drive(0, 1, 1, 1, 0);
      advance();
    end
    for (int c = 0; c < 10; c++) begin
      drive(0, 0, 0, 0, 0);
      advance();
    end
    chk("drop_cnt saturated", int'(drop_cnt), 16'hFFFF);
    chk("overflow with drops", int'(overflow), 1);
    drive(1, 0, 0, 0, 0);
    advance();
    drive(0, 0, 0, 0, 0);
    chk("drop_cnt cleared", int'(drop_cnt), 0);
    chk("overflow cleared", int'(overflow), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
